flash_record_ctrl: RTL and testbench
====================================

// Module: flash_record_ctrl
// PURPOSE
//  Upstream sequencer for the pmod_sf3 SPI flash master. It stores one game record
//  (e.g. high scores) between the game logic and the SF3 flash.
//  Save: for each byte it issues WREN (0x06), then PP (0x02) with 1 byte.
//  Load: for each byte it issues READ (0x03) with 1 byte and captures the result.
//  It drives the start/cmd/addr/data_in/data_len handshake and consumes data_out/done.
// PARAMETERS
//  RECORD_BYTES    8          bytes per record, 1..16
//  BASE_ADDR       24'h000000 flash address of record byte 0
//  TIMEOUT_CYCLES  1000000    clk cycles allowed per flash transaction before error
// PORTS
//  clk           in   1   system clock
//  reset         in   1   synchronous, active-high reset
//  save_req      in   1   pulse: write the buffer to flash
//  load_req      in   1   pulse: read flash into the buffer
//  buf_we        in   1   host write strobe into the record buffer
//  buf_addr      in   4   host byte index for write/read
//  buf_wdata     in   8   host write data
//  buf_rdata     out  8   registered buffer[buf_addr], 1-cycle latency
//  busy          out  1   high from accepted request until op_done
//  op_done       out  1   1-cycle pulse at the end of a save/load
//  op_err        out  1   1-cycle pulse, coincident with op_done, on timeout
//  flash_start   out  1   1-cycle start pulse to pmod_sf3
//  flash_cmd     out  8   command byte
//  flash_addr    out  24  byte address
//  flash_data_in out  8   PP data byte
//  flash_len     out  8   always 8'd1
//  flash_data_out in  8   read byte from pmod_sf3
//  flash_done    in   1   transaction-complete pulse from pmod_sf3
// BEHAVIOUR
//  - One clock domain; reset is synchronous, active-high.
//  - Reset values:
//    - busy, op_done, op_err, flash_start = 0; flash_cmd, flash_data_in = 8'h00.
//    - flash_addr = BASE_ADDR; flash_len = 1; buf_rdata = 0; buffer cleared to 0.
//    - State = IDLE.
//  - Reset mid-operation drops to IDLE with no done pulse.
//    - The shared reset also resets pmod_sf3, so a partial SPI frame is abandoned.
//  - States: IDLE, WREN_GO, WREN_WAIT, PP_GO, PP_WAIT, RD_GO, RD_WAIT, NEXT, FINISH.
//  - IDLE:
//    - save_req -> WREN_GO with idx = 0.
//    - Else load_req -> RD_GO with idx = 0.
//    - Save wins if both requests are high in the same cycle.
//    - Requests are ignored while busy.
//  - *_GO: assert flash_start for exactly 1 cycle, then enter the matching *_WAIT.
//    - cmd/addr/data_in are set on *_GO entry and held stable until flash_done.
//  - flash_addr = BASE_ADDR + idx, computed modulo 2^24 (wraps at 24'hFFFFFF).
//  - flash_data_in = buffer[idx] for PP; 8'h00 otherwise.
//  - WREN_WAIT: on flash_done -> PP_GO.
//  - PP_WAIT: on flash_done -> NEXT.
//    - pmod_sf3 does the WIP polling internally, so its done means the write is complete.
//  - RD_WAIT: on flash_done, buffer[idx] <= flash_data_out, then -> NEXT.
//  - NEXT:
//    - If idx == RECORD_BYTES-1 -> FINISH.
//    - Else idx++ and return to WREN_GO (save) or RD_GO (load).
//  - FINISH: op_done = 1 for 1 cycle, busy falls the next cycle, then -> IDLE.
//  - Timeout:
//    - A cycle counter is cleared on entry to each *_WAIT state.
//    - If it reaches TIMEOUT_CYCLES-1 with no flash_done: op_done = op_err = 1 for 1 cycle, then IDLE.
//    - A load that times out leaves the bytes already read updated and the rest unchanged.
//  - A flash_done pulse outside the *_WAIT states is ignored.
//  - Host buffer access:
//    - buf_we is honoured only when busy = 0.
//    - buf_addr >= RECORD_BYTES: writes are dropped and reads return 8'h00.
//  - Erase is out of scope. The target region must be pre-erased (0xFF); PP can only clear bits.
//  - Latency: 1 cycle from request to busy high; 2 cycles from the last flash_done to op_done.
// STRUCTURE
//  - Package flash_cmd_pkg: CMD_READ = 8'h03, CMD_WREN = 8'h06, CMD_PP = 8'h02,
//    CMD_RDSR = 8'h05, and the state encoding localparams.
//    The command constants are shared with pmod_sf3.
//  - Sub-module record_buffer: RECORD_BYTES x 8 register file.
//    - Host write port and registered host read port.
//    - Sequencer write port, which wins over the host write port.
//    - Combinational sequencer read port.
//  - The FSM, idx counter and timeout counter are in the top level.
// TESTING
//  - Save with a flash model: write buffer 0..7 = 8'hA0..A7, pulse save_req ->
//    8 WREN/PP pairs, addr 0..7, data A0..A7, flash_len = 1, one op_done, op_err = 0.
//  - Load: flash holds 8'h5A at addr 3, pulse load_req ->
//    8 READ commands, then buf_addr = 3 reads 8'h5A one cycle later.
//  - Simultaneous requests: save_req and load_req high together ->
//    the first flash_cmd is 8'h06.
//  - Busy lockout: save_req, load_req and buf_we pulsed during busy ->
//    no extra operation and the buffer is unchanged.
//  - Timeout: TIMEOUT_CYCLES = 100, flash_done never returned ->
//    op_done and op_err pulse 100 cycles after the first start, then busy = 0.
//  - Reset mid-save (during PP_WAIT of byte 2) -> all outputs at reset values the next cycle.
//    A following load runs normally.
//  - Wrap: BASE_ADDR = 24'hFFFFFE, RECORD_BYTES = 4 -> addresses FFFFFE, FFFFFF, 000000, 000001.

Source files
------------

// File: rtl/flash_cmd_pkg.sv
// SPI flash opcodes shared with pmod_sf3, plus the record sequencer state encoding.
package flash_cmd_pkg;

    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_WREN = 8'h06;
    localparam logic [7:0] CMD_PP   = 8'h02;
    localparam logic [7:0] CMD_RDSR = 8'h05;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_WREN_GO   = 4'd1;
    localparam logic [3:0] ST_WREN_WAIT = 4'd2;
    localparam logic [3:0] ST_PP_GO     = 4'd3;
    localparam logic [3:0] ST_PP_WAIT   = 4'd4;
    localparam logic [3:0] ST_RD_GO     = 4'd5;
    localparam logic [3:0] ST_RD_WAIT   = 4'd6;
    localparam logic [3:0] ST_NEXT      = 4'd7;
    localparam logic [3:0] ST_FINISH    = 4'd8;

    typedef enum logic [3:0] {
        IDLE      = ST_IDLE,
        WREN_GO   = ST_WREN_GO,
        WREN_WAIT = ST_WREN_WAIT,
        PP_GO     = ST_PP_GO,
        PP_WAIT   = ST_PP_WAIT,
        RD_GO     = ST_RD_GO,
        RD_WAIT   = ST_RD_WAIT,
        NEXT      = ST_NEXT,
        FINISH    = ST_FINISH
    } state_t;

    function automatic logic is_wait(input state_t s);
        return (s == WREN_WAIT) || (s == PP_WAIT) || (s == RD_WAIT);
    endfunction

    // Commands whose transaction hands a byte back on data_out.
    function automatic logic cmd_returns_data(input logic [7:0] cmd);
        return (cmd == CMD_READ) || (cmd == CMD_RDSR);
    endfunction

endpackage

// File: rtl/record_buffer.sv
// Record register file: host write port plus registered host read, and a sequencer
// write port (priority over host) with a combinational sequencer read.
module record_buffer #(
    parameter int unsigned RECORD_BYTES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       host_we_i,
    input  logic [3:0] host_addr_i,
    input  logic [7:0] host_wdata_i,
    output logic [7:0] host_rdata_o,
    input  logic       seq_we_i,
    input  logic [3:0] seq_waddr_i,
    input  logic [7:0] seq_wdata_i,
    input  logic [3:0] seq_raddr_i,
    output logic [7:0] seq_rdata_o
);

    logic [7:0] mem_q [RECORD_BYTES];
    logic [7:0] rdata_q;
    logic [7:0] rdata_d;

    // Address decode by compare keeps out-of-range indices harmless: writes miss, reads give 0.
    always_comb begin
        rdata_d     = 8'h00;
        seq_rdata_o = 8'h00;
        for (int i = 0; i < int'(RECORD_BYTES); i++) begin
            if (host_addr_i == 4'(i)) rdata_d = mem_q[i];
            if (seq_raddr_i == 4'(i)) seq_rdata_o = mem_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(RECORD_BYTES); i++) mem_q[i] <= 8'h00;
            rdata_q <= 8'h00;
        end else begin
            for (int i = 0; i < int'(RECORD_BYTES); i++) begin
                if (seq_we_i && (seq_waddr_i == 4'(i))) begin
                    mem_q[i] <= seq_wdata_i;
                end else if (host_we_i && (host_addr_i == 4'(i))) begin
                    mem_q[i] <= host_wdata_i;
                end
            end
            rdata_q <= rdata_d;
        end
    end

    assign host_rdata_o = rdata_q;

endmodule

// File: rtl/flash_record_ctrl.sv
// Saves/loads a small game record to SPI flash, one single-byte pmod_sf3 transaction
// at a time (WREN+PP per byte on save, READ per byte on load).
module flash_record_ctrl #(
    parameter int unsigned RECORD_BYTES   = 8,
    parameter logic [23:0] BASE_ADDR      = 24'h000000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        save_req,
    input  logic        load_req,
    input  logic        buf_we,
    input  logic [3:0]  buf_addr,
    input  logic [7:0]  buf_wdata,
    output logic [7:0]  buf_rdata,
    output logic        busy,
    output logic        op_done,
    output logic        op_err,
    output logic        flash_start,
    output logic [7:0]  flash_cmd,
    output logic [23:0] flash_addr,
    output logic [7:0]  flash_data_in,
    output logic [7:0]  flash_len,
    input  logic [7:0]  flash_data_out,
    input  logic        flash_done
);
    import flash_cmd_pkg::*;

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       IDX_LAST = 4'(RECORD_BYTES - 1);

    state_t           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             save_q, save_d;
    logic [7:0]       cmd_q;
    logic [23:0]      addr_q;
    logic [7:0]       din_q;
    logic             timeout_hit;
    logic             seq_we;
    logic             host_we;
    logic [7:0]       seq_rdata;

    assign timeout_hit = is_wait(state_q) && !flash_done && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= '0;
            save_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            save_q  <= save_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        save_d  = save_q;
        case (state_q)
            IDLE: begin
                if (save_req) begin
                    state_d = WREN_GO;
                    idx_d   = 4'd0;
                    save_d  = 1'b1;
                end else if (load_req) begin
                    state_d = RD_GO;
                    idx_d   = 4'd0;
                    save_d  = 1'b0;
                end
            end
            WREN_GO: begin
                state_d = WREN_WAIT;
                cnt_d   = '0;
            end
            PP_GO: begin
                state_d = PP_WAIT;
                cnt_d   = '0;
            end
            RD_GO: begin
                state_d = RD_WAIT;
                cnt_d   = '0;
            end
            WREN_WAIT, PP_WAIT, RD_WAIT: begin
                if (flash_done) begin
                    state_d = (state_q == WREN_WAIT) ? PP_GO : NEXT;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            NEXT: begin
                if (idx_q == IDX_LAST) begin
                    state_d = FINISH;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = save_q ? WREN_GO : RD_GO;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        flash_start = 1'b0;
        op_done     = 1'b0;
        op_err      = 1'b0;
        seq_we      = 1'b0;
        busy        = (state_q != IDLE);
        case (state_q)
            WREN_GO, PP_GO, RD_GO: flash_start = 1'b1;
            RD_WAIT:               seq_we      = flash_done;
            FINISH:                op_done     = 1'b1;
            default: ;
        endcase
        if (timeout_hit) begin
            op_done = 1'b1;
            op_err  = 1'b1;
        end
    end

    // Transaction fields load on entry to a *_GO state and hold through the wait.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q  <= 8'h00;
            addr_q <= BASE_ADDR;
            din_q  <= 8'h00;
        end else begin
            case (state_d)
                WREN_GO: begin
                    cmd_q  <= CMD_WREN;
                    addr_q <= BASE_ADDR + {20'd0, idx_d};
                    din_q  <= 8'h00;
                end
                PP_GO: begin
                    cmd_q  <= CMD_PP;
                    addr_q <= BASE_ADDR + {20'd0, idx_d};
                    din_q  <= seq_rdata;
                end
                RD_GO: begin
                    cmd_q  <= CMD_READ;
                    addr_q <= BASE_ADDR + {20'd0, idx_d};
                    din_q  <= 8'h00;
                end
                default: ;
            endcase
        end
    end

    assign flash_cmd     = cmd_q;
    assign flash_addr    = addr_q;
    assign flash_data_in = din_q;
    assign flash_len     = 8'd1;
    assign host_we       = buf_we && !busy;

    record_buffer #(
        .RECORD_BYTES(RECORD_BYTES)
    ) u_buf (
        .clk         (clk),
        .reset       (reset),
        .host_we_i   (host_we),
        .host_addr_i (buf_addr),
        .host_wdata_i(buf_wdata),
        .host_rdata_o(buf_rdata),
        .seq_we_i    (seq_we),
        .seq_waddr_i (idx_q),
        .seq_wdata_i (flash_data_out),
        .seq_raddr_i (idx_d),
        .seq_rdata_o (seq_rdata)
    );

endmodule

// File: tb/tb_flash_record_ctrl.sv
// Scoreboard bench for flash_record_ctrl with a behavioural pmod_sf3/flash model.
module tb_flash_record_ctrl;

    localparam int TO = 100;

    typedef struct packed {
        logic [7:0]  cmd;
        logic [23:0] addr;
        logic [7:0]  din;
    } txn_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        save_req, load_req, buf_we;
    logic [3:0]  buf_addr;
    logic [7:0]  buf_wdata, buf_rdata;
    logic        busy, op_done, op_err, flash_start;
    logic [7:0]  flash_cmd, flash_data_in, flash_len, flash_data_out;
    logic [23:0] flash_addr;
    logic        flash_done;

    logic        save_req_w, flash_done_w;
    logic [7:0]  buf_rdata_w, flash_cmd_w, flash_data_in_w, flash_len_w;
    logic [23:0] flash_addr_w;
    logic        busy_w, op_done_w, op_err_w, flash_start_w;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    txn_t exp_q[$];
    txn_t exp_w[$];
    logic op_q[$];
    logic [7:0] fmem [256];
    logic [7:0] bufm [16];
    bit   mute;
    int   n_starts = 0;
    int   last_start_cyc = 0;
    int   last_done_cyc = 0;
    logic [23:0] hold_addr = 24'h0;
    bit   wrap_done_seen = 1'b0;
    txn_t mon_t, mon_tw;
    logic mon_e;
    logic [23:0] wrap_addrs [4] = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'h000001};

    flash_record_ctrl #(
        .RECORD_BYTES(8), .BASE_ADDR(24'h000000), .TIMEOUT_CYCLES(TO)
    ) u_dut (
        .clk(clk), .reset(reset), .save_req(save_req), .load_req(load_req),
        .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata), .buf_rdata(buf_rdata),
        .busy(busy), .op_done(op_done), .op_err(op_err), .flash_start(flash_start),
        .flash_cmd(flash_cmd), .flash_addr(flash_addr), .flash_data_in(flash_data_in),
        .flash_len(flash_len), .flash_data_out(flash_data_out), .flash_done(flash_done)
    );

    flash_record_ctrl #(
        .RECORD_BYTES(4), .BASE_ADDR(24'hFFFFFE), .TIMEOUT_CYCLES(TO)
    ) u_wrap (
        .clk(clk), .reset(reset), .save_req(save_req_w), .load_req(1'b0),
        .buf_we(1'b0), .buf_addr(4'd0), .buf_wdata(8'h00), .buf_rdata(buf_rdata_w),
        .busy(busy_w), .op_done(op_done_w), .op_err(op_err_w), .flash_start(flash_start_w),
        .flash_cmd(flash_cmd_w), .flash_addr(flash_addr_w), .flash_data_in(flash_data_in_w),
        .flash_len(flash_len_w), .flash_data_out(8'h00), .flash_done(flash_done_w)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Main scoreboard: transactions and op completions are popped as the DUT emits them.
    always @(negedge clk) begin
        if (flash_start) begin
            n_starts++;
            last_start_cyc = cyc;
            hold_addr = flash_addr;
            if (exp_q.size() == 0) begin
                chk("unexpected_start", 1, 0);
            end else begin
                mon_t = exp_q.pop_front();
                chk("txn_cmd", flash_cmd, mon_t.cmd);
                chk("txn_addr", flash_addr, mon_t.addr);
                chk("txn_din", flash_data_in, mon_t.din);
                chk("txn_len", flash_len, 8'd1);
            end
        end
        if (flash_done && busy) begin
            last_done_cyc = cyc;
            chk("addr_hold", flash_addr, hold_addr);
        end
        if (op_done) begin
            if (op_q.size() == 0) begin
                chk("unexpected_op_done", 1, 0);
            end else begin
                mon_e = op_q.pop_front();
                chk("op_err", op_err, mon_e);
                if (mon_e) chk("timeout_latency", cyc - last_start_cyc, TO);
                else       chk("done_latency", cyc - last_done_cyc, 2);
            end
        end else if (op_err) begin
            chk("err_without_done", 1, 0);
        end
    end

    always @(negedge clk) begin
        if (flash_start_w) begin
            if (exp_w.size() == 0) begin
                chk("wrap_unexpected_start", 1, 0);
            end else begin
                mon_tw = exp_w.pop_front();
                chk("wrap_cmd", flash_cmd_w, mon_tw.cmd);
                chk("wrap_addr", flash_addr_w, mon_tw.addr);
                chk("wrap_din", flash_data_in_w, mon_tw.din);
                chk("wrap_len", flash_len_w, 8'd1);
            end
        end
        if (op_done_w) begin
            wrap_done_seen = 1'b1;
            chk("wrap_err", op_err_w, 0);
        end
    end

    // Flash model: done 3 cycles into the wait; READ returns fmem, PP can only clear bits.
    logic        s_start, s_reset;
    logic [7:0]  s_cmd, s_din, p_cmd, p_din;
    logic [23:0] s_addr, p_addr;
    int          pend;
    initial begin
        flash_done = 1'b0;
        flash_data_out = 8'h00;
        pend = 0;
        forever begin
            @(negedge clk);
            s_start = flash_start; s_reset = reset;
            s_cmd = flash_cmd; s_addr = flash_addr; s_din = flash_data_in;
            @(posedge clk); #1;
            flash_done = 1'b0;
            if (s_reset === 1'b1) begin
                pend = 0;
            end else if (pend != 0) begin
                pend--;
                if (pend == 0) begin
                    flash_done = 1'b1;
                    if (p_cmd == 8'h03) flash_data_out = fmem[p_addr[7:0]];
                    else if (p_cmd == 8'h02) fmem[p_addr[7:0]] = fmem[p_addr[7:0]] & p_din;
                end
            end else if (s_start === 1'b1 && !mute) begin
                pend = 3; p_cmd = s_cmd; p_addr = s_addr; p_din = s_din;
            end
        end
    end

    logic sw_start, sw_reset;
    int   pend_w;
    initial begin
        flash_done_w = 1'b0;
        pend_w = 0;
        forever begin
            @(negedge clk);
            sw_start = flash_start_w; sw_reset = reset;
            @(posedge clk); #1;
            flash_done_w = 1'b0;
            if (sw_reset === 1'b1) pend_w = 0;
            else if (pend_w != 0) begin
                pend_w--;
                if (pend_w == 0) flash_done_w = 1'b1;
            end else if (sw_start === 1'b1) pend_w = 2;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push_txn(input logic [7:0] c, input logic [23:0] a, input logic [7:0] d);
        txn_t t;
        t.cmd = c; t.addr = a; t.din = d;
        exp_q.push_back(t);
    endtask

    task automatic push_save(input int n);
        for (int i = 0; i < n; i++) begin
            push_txn(8'h06, 24'(i), 8'h00);
            push_txn(8'h02, 24'(i), bufm[i]);
        end
    endtask

    task automatic push_load();
        for (int i = 0; i < 8; i++) begin
            push_txn(8'h03, 24'(i), 8'h00);
            bufm[i] = fmem[i];
        end
    endtask

    task automatic pulse(input logic s, input logic l);
        save_req = s; load_req = l;
        tick();
        save_req = 1'b0; load_req = 1'b0;
    endtask

    task automatic buf_write(input logic [3:0] a, input logic [7:0] d);
        buf_we = 1'b1; buf_addr = a; buf_wdata = d;
        tick();
        buf_we = 1'b0;
    endtask

    task automatic buf_check(input logic [3:0] a, input logic [7:0] e, input string tag);
        buf_addr = a;
        tick();
        chk(tag, buf_rdata, e);
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int k;
        k = 0;
        while ((op_q.size() != 0 || busy) && k < limit) begin
            tick();
            k++;
        end
        chk({tag, "_in_time"}, k < limit, 1);
    endtask

    task automatic check_reset(input string p);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_op_done"}, op_done, 0);
        chk({p, "_op_err"}, op_err, 0);
        chk({p, "_start"}, flash_start, 0);
        chk({p, "_cmd"}, flash_cmd, 8'h00);
        chk({p, "_din"}, flash_data_in, 8'h00);
        chk({p, "_addr"}, flash_addr, 24'h000000);
        chk({p, "_len"}, flash_len, 8'd1);
        chk({p, "_rdata"}, buf_rdata, 8'h00);
    endtask

    initial begin
        int k;
        txn_t tw;
        reset = 1'b1; save_req = 1'b0; load_req = 1'b0; buf_we = 1'b0;
        buf_addr = 4'd0; buf_wdata = 8'h00; save_req_w = 1'b0; mute = 1'b0;
        for (int i = 0; i < 256; i++) fmem[i] = 8'hFF;
        for (int i = 0; i < 16; i++) bufm[i] = 8'h00;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        check_reset("rst");

        tick();
        for (int i = 0; i < 8; i++) begin
            buf_write(4'(i), 8'hA0 + 8'(i));
            bufm[i] = 8'hA0 + 8'(i);
        end
        buf_write(4'd9, 8'h77);
        buf_check(4'd9, 8'h00, "oob_read");
        buf_check(4'd2, 8'hA2, "host_rd2");

        // Save A0..A7 with request-to-busy latency check
        push_save(8);
        op_q.push_back(1'b0);
        save_req = 1'b1;
        @(negedge clk);
        chk("busy_pre", busy, 0);
        tick();
        save_req = 1'b0;
        @(negedge clk);
        chk("busy_lat", busy, 1);
        wait_idle("save", 400);

        fmem[3] = 8'h5A;
        push_load();
        op_q.push_back(1'b0);
        pulse(1'b0, 1'b1);
        wait_idle("load", 400);
        buf_check(4'd3, 8'h5A, "load_b3");
        buf_check(4'd0, 8'hA0, "load_b0");
        buf_check(4'd7, 8'hA7, "load_b7");

        // Both requests together: save must win
        push_save(8);
        op_q.push_back(1'b0);
        pulse(1'b1, 1'b1);
        wait_idle("both", 400);

        push_save(8);
        op_q.push_back(1'b0);
        pulse(1'b1, 1'b0);
        repeat (6) tick();
        save_req = 1'b1; load_req = 1'b1; buf_we = 1'b1; buf_addr = 4'd0; buf_wdata = 8'h11;
        tick();
        save_req = 1'b0; load_req = 1'b0; buf_we = 1'b0;
        wait_idle("lock", 400);
        repeat (20) tick();
        chk("lock_no_extra", exp_q.size(), 0);
        chk("lock_busy", busy, 0);
        buf_check(4'd0, 8'hA0, "lock_buf0");

        mute = 1'b1;
        push_txn(8'h06, 24'h000000, 8'h00);
        op_q.push_back(1'b1);
        pulse(1'b1, 1'b0);
        wait_idle("timeout", 400);
        chk("to_busy", busy, 0);
        mute = 1'b0;

        // Reset while byte 2 is in PP_WAIT
        push_save(3);
        k = n_starts;
        pulse(1'b1, 1'b0);
        while (n_starts < k + 6 && (n_starts - k) < 7 && cyc < 60000) tick();
        chk("mid_reach_pp2", n_starts - k, 6);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check_reset("mid");
        for (int i = 0; i < 16; i++) bufm[i] = 8'h00;

        tick();
        push_load();
        op_q.push_back(1'b0);
        pulse(1'b0, 1'b1);
        wait_idle("reload", 400);
        buf_check(4'd3, 8'h5A, "reload_b3");
        buf_check(4'd6, 8'hA6, "reload_b6");

        for (int i = 0; i < 4; i++) begin
            tw.cmd = 8'h06; tw.addr = wrap_addrs[i]; tw.din = 8'h00; exp_w.push_back(tw);
            tw.cmd = 8'h02; exp_w.push_back(tw);
        end
        save_req_w = 1'b1;
        tick();
        save_req_w = 1'b0;
        k = 0;
        while (!wrap_done_seen && k < 300) begin
            tick();
            k++;
        end
        chk("wrap_done", wrap_done_seen, 1);
        chk("wrap_sb_empty", exp_w.size(), 0);
        tick();
        chk("wrap_busy", busy_w, 0);
        chk("wrap_rdata", buf_rdata_w, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish within 50000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
